// File: rtl/ft_cmd_regbank_pkg.sv
// Shared constants for the FT600 command register bank: op codes, register map,
// response codes, CTRL layout and FSM state encodings.
package ft_cmd_regbank_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ID      = 6'h00;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = 6'h01;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = 6'h02;
  localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH = 6'h03;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CMDCNT  = 6'h04;

  localparam logic [1:0] RSP_OK  = 2'b10;
  localparam logic [1:0] RSP_ERR = 2'b11;

  localparam int CTRL_LOOPBACK  = 0;
  localparam int CTRL_TX_MUX    = 1;
  localparam int CTRL_RX_MUX    = 2;
  localparam int CTRL_TX_LED    = 3;
  localparam int CTRL_RX_LED    = 4;
  localparam int CTRL_AFE_TX_EN = 5;
  localparam int CTRL_AFE_RX_EN = 6;
  localparam int CTRL_AFE_RESET = 7;
  localparam logic [7:0] CTRL_RESET = 8'h81;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            tag;
    logic [15:0]           data;
  } cmd_word_t;

endpackage

// File: rtl/ft_cmd_regbank_fifo.sv
// Input skid FIFO for host command words; flags a one-cycle overflow pulse when a
// word arrives while full and nothing is popped in the same cycle.
module cmd_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign w_push  = push_i && (!full_o || w_pop);
  assign ovf_o   = push_i && !w_push;
  assign dout_o  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/ft_cmd_regbank.sv
// Executes host register read/write commands against the board control bank and
// returns one response word per non-NOP command. FSM: IDLE -> EXEC -> RESP.
import ft_cmd_regbank_pkg::*;

module ft_cmd_regbank #(
  parameter int          IN_DEPTH = 4,
  parameter logic [15:0] ID_VALUE = 16'h5D50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_we_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_we_o,
  input  logic        rsp_full_i,
  input  logic [7:0]  status_i,
  output logic [7:0]  ctrl_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_fifo_full_o
);
  logic [1:0]  r_state;
  cmd_word_t   r_cmd;
  logic [31:0] r_rsp;
  logic [7:0]  r_ctrl;
  logic [15:0] r_scratch;
  logic [15:0] r_cmdcnt;
  logic        r_ovf;

  logic [31:0] w_fifo_dout;
  logic        w_empty;
  logic        w_full;
  logic        w_ovf_set;
  logic        w_pop;
  logic        w_exec;
  logic        w_err;
  logic [15:0] w_rdata;
  logic        w_wr_ctrl;
  logic        w_wr_scratch;
  logic        w_clr_ovf;

  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_exec = (r_state == ST_EXEC);

  cmd_skid_fifo #(.DEPTH(IN_DEPTH), .W(DATA_WIDTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (cmd_we_i),
    .din_i  (cmd_data_i),
    .pop_i  (w_pop),
    .dout_o (w_fifo_dout),
    .full_o (w_full),
    .empty_o(w_empty),
    .ovf_o  (w_ovf_set)
  );

  // rdata is the register value after any write this command performs.
  always_comb begin
    w_err        = 1'b0;
    w_rdata      = 16'h0000;
    w_wr_ctrl    = 1'b0;
    w_wr_scratch = 1'b0;
    w_clr_ovf    = 1'b0;
    case (r_cmd.op)
      OP_READ: begin
        case (r_cmd.addr)
          ADDR_ID:      w_rdata = ID_VALUE;
          ADDR_CTRL:    w_rdata = {8'h00, r_ctrl};
          ADDR_STATUS:  w_rdata = {7'b0, r_ovf, status_i};
          ADDR_SCRATCH: w_rdata = r_scratch;
          ADDR_CMDCNT:  w_rdata = r_cmdcnt;
          default:      w_err   = 1'b1;
        endcase
      end
      OP_WRITE: begin
        case (r_cmd.addr)
          ADDR_CTRL: begin
            w_wr_ctrl = w_exec;
            w_rdata   = {8'h00, r_cmd.data[7:0]};
          end
          ADDR_STATUS: begin
            w_clr_ovf = w_exec && r_cmd.data[8];
            w_rdata   = {7'b0, r_ovf && !r_cmd.data[8], status_i};
          end
          ADDR_SCRATCH: begin
            w_wr_scratch = w_exec;
            w_rdata      = r_cmd.data;
          end
          default: w_err = 1'b1;
        endcase
      end
      OP_RSVD: w_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_rsp     <= '0;
      r_ctrl    <= CTRL_RESET;
      r_scratch <= '0;
      r_cmdcnt  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd   <= cmd_word_t'(w_fifo_dout);
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cmd.op == OP_NOP) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_wr_ctrl)    r_ctrl    <= r_cmd.data[7:0];
            if (w_wr_scratch) r_scratch <= r_cmd.data;
            r_rsp    <= {w_err ? RSP_ERR : RSP_OK, r_cmd.addr, r_cmd.tag,
                         w_err ? 16'h0000 : w_rdata};
            r_cmdcnt <= r_cmdcnt + 16'd1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_full_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake: a response word is delivered in the single cycle where the FSM is
  // in RESP and the response FIFO is not full; while full, rsp_data_o is held.
  assign rsp_we_o        = (r_state == ST_RESP) && !rsp_full_i && !reset;
  assign rsp_data_o      = r_rsp;
  assign ctrl_o          = r_ctrl;
  assign busy_o          = (r_state != ST_IDLE) || !w_empty;
  assign dbg_state_o     = r_state;
  assign dbg_fifo_full_o = w_full;

endmodule
